// File: rtl/alu_pkg.sv
// Shared types and constants for the nibble-serial word ALU.
package alu_pkg;

    // Sequencer states: wait for a request, ripple nibbles, present result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 74181 function selects for the common operations.
    localparam logic [3:0] S_ADD  = 4'b1001;  // m=0: A plus B plus carry
    localparam logic [3:0] S_SUB  = 4'b0110;  // m=0: A minus B minus 1 plus carry
    localparam logic [3:0] S_XOR  = 4'b0110;  // m=1: A xor B
    localparam logic [3:0] S_AND  = 4'b1011;  // m=1: A and B
    localparam logic [3:0] S_OR   = 4'b1110;  // m=1: A or B
    localparam logic [3:0] S_NOTA = 4'b0000;  // m=1: not A

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181-style slice, active-high data, active-low carries.
module alu181_slice (
    input  logic [3:0] s,
    input  logic       m,
    input  logic       ci_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] f,
    output logic       co_n
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;
    logic       cin;

    // Per-bit propagate/generate: arithmetic result is p + g + carry, and g implies p.
    always_comb begin
        p    = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        g    = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        cin  = ~ci_n;
        // Full lookahead carries into each bit position.
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        co_n = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & cin));
        // Logic mode ignores carries; the half-sum is inverted to give the 74181 logic table.
        f    = m ? ~(p ^ g) : (p ^ g ^ c);
    end

endmodule

// File: rtl/alu_word_seq.sv
// Word ALU that sequences one alu181_slice over WIDTH/4 nibbles, LSB first.
module alu_word_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             ci_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             co_n,
    output logic             zero
);
    import alu_pkg::*;

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [3:0]        s_reg;
    logic              m_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [WIDTH-1:0]  y_reg;
    logic              accept;

    logic [3:0]        a_nib [NIB];
    logic [3:0]        b_nib [NIB];
    logic [3:0]        slice_f;
    logic              slice_co_n;

    // Split the latched operands into nibble lanes for the index mux.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
        end
    endgenerate

    alu181_slice u_slice (
        .s    (s_reg),
        .m    (m_reg),
        .ci_n (carry_reg),
        .a    (a_nib[idx_reg]),
        .b    (b_nib[idx_reg]),
        .f    (slice_f),
        .co_n (slice_co_n)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs; no request is taken outside IDLE.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: latch the request, then write one nibble and ripple the carry per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg     <= '0;
            m_reg     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b1;
            idx_reg   <= '0;
            y_reg     <= '0;
        end else if (accept) begin
            s_reg     <= s;
            m_reg     <= m;
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= ci_n;
            idx_reg   <= '0;
            y_reg     <= '0;
        end else if (state_reg == ST_RUN) begin
            y_reg[idx_reg*4 +: 4] <= slice_f;
            if (!m_reg) begin
                carry_reg <= slice_co_n;
            end
            idx_reg <= idx_reg + IDXW'(1);
        end
    end

    // Carry-out only reflects the ripple for a finished arithmetic result.
    assign y    = y_reg;
    assign co_n = (state_reg == ST_DONE && !m_reg) ? carry_reg : 1'b1;
    assign zero = (state_reg == ST_DONE) && (y_reg == '0);

endmodule

// File: tb/tb_alu_word_seq.sv
// Bench for alu_word_seq: directed cases, backpressure, mid-run reset, random ops.
module tb_alu_word_seq;
    import alu_pkg::*;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       s = 4'h0;
    logic             m = 1'b0;
    logic             ci_n = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] y;
    logic             co_n;
    logic             zero;

    int checks = 0;
    int errors = 0;

    logic [3:0] op_s [6];
    logic       op_m [6];

    alu_word_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .m         (m),
        .ci_n      (ci_n),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .co_n      (co_n),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: returns {co_n, y} for the supported operations.
    function automatic logic [WIDTH:0] ref_alu(input logic [3:0] sv, input logic mv,
                                               input logic civ, input logic [WIDTH-1:0] av,
                                               input logic [WIDTH-1:0] bv);
        logic [WIDTH:0] sum;
        logic [WIDTH:0] cin;
        cin = {{WIDTH{1'b0}}, ~civ};
        sum = '0;
        if (!mv) begin
            if (sv == S_ADD) sum = {1'b0, av} + {1'b0, bv} + cin;
            else             sum = {1'b0, av} + {1'b0, ~bv} + cin;   // S_SUB
            return {~sum[WIDTH], sum[WIDTH-1:0]};
        end
        case (sv)
            S_XOR:   return {1'b1, av ^ bv};
            S_AND:   return {1'b1, av & bv};
            S_OR:    return {1'b1, av | bv};
            default: return {1'b1, ~av};                           // S_NOTA
        endcase
    endfunction

    // One full transaction; hold = cycles of backpressure with in_valid high and operands churning.
    task automatic run_op(input string tag, input logic [3:0] sv, input logic mv, input logic civ,
                          input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] ey, input logic eco, input int hold);
        @(negedge clk);
        chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        s = sv; m = mv; ci_n = civ; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        for (int i = 1; i <= NIB; i++) begin
            @(posedge clk);
            #1;
            if (i < NIB) begin
                chk($sformatf("%s out_valid early c%0d", tag, i), 32'(out_valid), 32'd0);
            end else begin
                chk({tag, " out_valid at latency"}, 32'(out_valid), 32'd1);
                chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
            end
        end
        chk({tag, " y"}, 32'(y), 32'(ey));
        chk({tag, " co_n"}, 32'(co_n), 32'(eco));
        chk({tag, " zero"}, 32'(zero), 32'(ey == '0));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            @(posedge clk);
            #1;
            chk($sformatf("%s hold%0d y", tag, h), 32'(y), 32'(ey));
            chk($sformatf("%s hold%0d co_n", tag, h), 32'(co_n), 32'(eco));
            chk($sformatf("%s hold%0d zero", tag, h), 32'(zero), 32'(ey == '0));
            chk($sformatf("%s hold%0d out_valid", tag, h), 32'(out_valid), 32'd1);
            chk($sformatf("%s hold%0d in_ready", tag, h), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
        chk({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
        $display("txn %s: s=%b m=%b ci_n=%b a=%h b=%h -> y=%h co_n=%b (expect %h/%b)",
                 tag, sv, mv, civ, av, bv, ey, eco, ey, eco);
    endtask

    initial begin
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        int               k;

        op_s = '{S_ADD, S_SUB, S_XOR, S_AND, S_OR, S_NOTA};
        op_m = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state while held and after release.
        #2;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst y", 32'(y), 32'd0);
        chk("rst co_n", 32'(co_n), 32'd1);
        chk("rst zero", 32'(zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst out_valid", 32'(out_valid), 32'd0);

        // Directed cases.
        run_op("add",      S_ADD,  1'b0, 1'b1, 16'h1234, 16'h0FCD, 16'h2201, 1'b1, 0);
        run_op("add_wrap", S_ADD,  1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 0);
        run_op("sub_neg",  S_SUB,  1'b0, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 0);
        run_op("sub_pos",  S_SUB,  1'b0, 1'b0, 16'h0007, 16'h0005, 16'h0002, 1'b0, 0);
        run_op("xor",      S_XOR,  1'b1, 1'b1, 16'hA5A5, 16'h0FF0, 16'hAA55, 1'b1, 0);
        run_op("nota",     S_NOTA, 1'b1, 1'b0, 16'h00FF, 16'h0000, 16'hFF00, 1'b1, 0);

        // Backpressure in DONE with in_valid asserted and operands changing.
        run_op("backpress", S_ADD, 1'b0, 1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b0, 5);

        // Reset after two nibbles of an add that leaves the carry register at 0.
        @(negedge clk);
        s = S_ADD; m = 1'b0; ci_n = 1'b0; a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrun rst in_ready", 32'(in_ready), 32'd1);
        chk("midrun rst out_valid", 32'(out_valid), 32'd0);
        chk("midrun rst y", 32'(y), 32'd0);
        chk("midrun rst co_n", 32'(co_n), 32'd1);
        chk("midrun rst zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NIB + 1; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-midrun out_valid c%0d", i), 32'(out_valid), 32'd0);
        end
        run_op("after_rst", S_ADD, 1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0002, 1'b1, 0);

        // Random operations against the word-level reference.
        for (int n = 0; n < 24; n++) begin
            k  = int'($urandom_range(0, 5));
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            r  = ref_alu(op_s[k], op_m[k], rc, ra, rb);
            run_op($sformatf("rnd%0d", n), op_s[k], op_m[k], rc, ra, rb,
                   r[WIDTH-1:0], r[WIDTH], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
